// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory-side signals of the data-memory arbiter
// slave: the arbiter; master: the requesters plus the memory that sits behind the arbiter.
interface dmem_arbiter_if;
  logic        m0_req_i;
  logic        m0_we_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_wdata_i;
  logic        m0_ack_o;
  logic [31:0] m0_rdata_o;
  logic        m1_req_i;
  logic        m1_we_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic        m1_ack_o;
  logic [31:0] m1_rdata_o;
  logic        err_o;
  logic        busy_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  mem_rdata_i,
    output m0_ack_o, m0_rdata_o, m1_ack_o, m1_rdata_o,
    output err_o, busy_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output mem_rdata_i,
    input  m0_ack_o, m0_rdata_o, m1_ack_o, m1_rdata_o,
    input  err_o, busy_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter for the single-port data memory
// One access in flight: IDLE -> ACCESS (LATENCY cycles) -> RESP (ack pulse) -> IDLE.
module dmem_arbiter #(
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned DEPTH      = 256,
  parameter bit          BYTE_ADDR  = 1'b1,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        last_grant;
  logic        grant;
  logic        we_q;
  logic        oor_q;
  logic [31:0] rdata_q;

  logic        win;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic [31:0] win_word;
  logic        win_oor;
  logic        any_req;

  always_comb begin
    any_req = bus.m0_req_i | bus.m1_req_i;
    win     = bus.m1_req_i;
    if (bus.m0_req_i && bus.m1_req_i)
      win = FIXED_PRIO ? 1'b0 : ~last_grant;
    win_we    = win ? bus.m1_we_i    : bus.m0_we_i;
    win_addr  = win ? bus.m1_addr_i  : bus.m0_addr_i;
    win_wdata = win ? bus.m1_wdata_i : bus.m0_wdata_i;
    win_word  = BYTE_ADDR ? {2'b00, win_addr[31:2]} : win_addr;
    win_oor   = (win_word >= DEPTH) || (BYTE_ADDR && (win_addr[1:0] != 2'b00));
  end

  assign bus.busy_o     = (state != IDLE);
  assign bus.m0_rdata_o = rdata_q;
  assign bus.m1_rdata_o = rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      last_grant      <= 1'b1;
      grant           <= 1'b0;
      we_q            <= 1'b0;
      oor_q           <= 1'b0;
      rdata_q         <= 32'd0;
      bus.m0_ack_o    <= 1'b0;
      bus.m1_ack_o    <= 1'b0;
      bus.err_o       <= 1'b0;
      bus.mem_read_o  <= 1'b0;
      bus.mem_write_o <= 1'b0;
      bus.mem_addr_o  <= 32'd0;
      bus.mem_wdata_o <= 32'd0;
    end else begin
      bus.m0_ack_o <= 1'b0;
      bus.m1_ack_o <= 1'b0;
      bus.err_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant           <= win;
            last_grant      <= win;
            we_q            <= win_we;
            oor_q           <= win_oor;
            cnt             <= CNT_INIT;
            bus.mem_addr_o  <= win_word;
            bus.mem_wdata_o <= win_wdata;
            // Out-of-range accesses walk the FSM with both strobes held low.
            bus.mem_read_o  <= !win_we && !win_oor;
            bus.mem_write_o <= win_we && !win_oor && (CNT_INIT == 4'd0);
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt             <= cnt - 4'd1;
            // The single write edge lands on the final ACCESS cycle.
            bus.mem_write_o <= we_q && !oor_q && (cnt == 4'd1);
          end else begin
            rdata_q         <= oor_q ? 32'd0 : bus.mem_rdata_i;
            bus.mem_read_o  <= 1'b0;
            bus.mem_write_o <= 1'b0;
            bus.m0_ack_o    <= !grant;
            bus.m1_ack_o    <= grant;
            bus.err_o       <= oor_q;
            state           <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
// Three instances: g0 LATENCY=1 round-robin, g1 LATENCY=1 fixed priority, g2 LATENCY=4 round-robin.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  logic [2:0][1:0]       req_v   = '0;
  logic [2:0][1:0]       we_v    = '0;
  logic [2:0][1:0][31:0] addr_v  = '0;
  logic [2:0][1:0][31:0] wdata_v = '0;
  logic [2:0][1:0]       ack_v;
  logic [2:0][1:0][31:0] rdata_v;
  logic [2:0]            err_v, busy_v, mrd_v, mwr_v;
  logic [2:0][31:0]      maddr_v, mwd_v;

  dmem_arbiter_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int unsigned LAT = (g == 2) ? 4 : 1;
    localparam bit          FP  = (g == 1);
    logic [31:0] mem [256] = '{default: '0};

    dmem_arbiter #(.LATENCY(LAT), .DEPTH(256), .BYTE_ADDR(1'b1), .FIXED_PRIO(FP)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus[g])
    );

    assign bus[g].m0_req_i   = req_v[g][0];
    assign bus[g].m0_we_i    = we_v[g][0];
    assign bus[g].m0_addr_i  = addr_v[g][0];
    assign bus[g].m0_wdata_i = wdata_v[g][0];
    assign bus[g].m1_req_i   = req_v[g][1];
    assign bus[g].m1_we_i    = we_v[g][1];
    assign bus[g].m1_addr_i  = addr_v[g][1];
    assign bus[g].m1_wdata_i = wdata_v[g][1];
    assign ack_v[g]          = {bus[g].m1_ack_o, bus[g].m0_ack_o};
    assign rdata_v[g][0]     = bus[g].m0_rdata_o;
    assign rdata_v[g][1]     = bus[g].m1_rdata_o;
    assign err_v[g]          = bus[g].err_o;
    assign busy_v[g]         = bus[g].busy_o;
    assign mrd_v[g]          = bus[g].mem_read_o;
    assign mwr_v[g]          = bus[g].mem_write_o;
    assign maddr_v[g]        = bus[g].mem_addr_o;
    assign mwd_v[g]          = bus[g].mem_wdata_o;
    assign bus[g].mem_rdata_i = mem[bus[g].mem_addr_o[7:0]];

    always @(posedge clk)
      if (bus[g].mem_write_o) mem[bus[g].mem_addr_o[7:0]] <= bus[g].mem_wdata_o;
  end

  // Strobe/ack activity counters, sampled on the falling edge.
  int wr_cnt [3] = '{default: 0};
  int rd_cnt [3] = '{default: 0};
  int both_cnt [3] = '{default: 0};
  int dual_cnt [3] = '{default: 0};
  int ack_cnt [3][2] = '{default: 0};
  logic [2:0][31:0] sa_v = '0, swd_v = '0;

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (mwr_v[g]) wr_cnt[g]++;
      if (mrd_v[g]) rd_cnt[g]++;
      if (mwr_v[g] && mrd_v[g]) both_cnt[g]++;
      if (ack_v[g][0] && ack_v[g][1]) dual_cnt[g]++;
      for (int p = 0; p < 2; p++) if (ack_v[g][p]) ack_cnt[g][p]++;
      if (mwr_v[g] || mrd_v[g]) begin
        sa_v[g]  = maddr_v[g];
        swd_v[g] = mwd_v[g];
      end
    end
  end

  // Reference model: memory contents and last granted port per instance.
  logic [31:0] ref_mem [3][256];
  int          ref_last [3];

  function automatic int lat_of(input int g);
    return (g == 2) ? 4 : 1;
  endfunction

  typedef struct {
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          nwr, nrd, nboth, nother;
    logic [31:0] saddr, swd;
  } res_t;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic xact(input int g, input int p, input bit we, input logic [31:0] addr,
                      input logic [31:0] wd, output res_t r);
    int wr0, rd0, b0, o0;
    wr0 = wr_cnt[g]; rd0 = rd_cnt[g]; b0 = both_cnt[g]; o0 = ack_cnt[g][1-p];
    req_v[g][p] = 1'b1; we_v[g][p] = we; addr_v[g][p] = addr; wdata_v[g][p] = wd;
    r.lat = 0;
    do begin
      tick();
      r.lat++;
    end while (!ack_v[g][p] && r.lat < 40);
    r.rd = rdata_v[g][p];
    r.er = err_v[g];
    req_v[g][p] = 1'b0;
    tick();
    r.nwr = wr_cnt[g] - wr0; r.nrd = rd_cnt[g] - rd0;
    r.nboth = both_cnt[g] - b0; r.nother = ack_cnt[g][1-p] - o0;
    r.saddr = sa_v[g]; r.swd = swd_v[g];
  endtask

  task automatic test_reset();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({ack_v[g], err_v[g], busy_v[g], mrd_v[g], mwr_v[g], maddr_v[g], mwd_v[g], rdata_v[g]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs g%0d: ack=%b err=%b busy=%b rd=%b wr=%b addr=%h wd=%h rdata=%h, want all 0",
                 g, ack_v[g], err_v[g], busy_v[g], mrd_v[g], mwr_v[g], maddr_v[g], mwd_v[g], rdata_v[g]);
      end
    end
  endtask

  task automatic test_write_read();
    res_t r;
    xact(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, r);
    ref_mem[0][4] = 32'hDEADBEEF; ref_last[0] = 0;
    checks++; if (r.lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", r.lat); end
    checks++; if (r.nwr !== 1 || r.nrd !== 0) begin errors++; $display("FAIL wr_strobes: wr=%0d rd=%0d want 1/0", r.nwr, r.nrd); end
    checks++; if (r.saddr !== 32'd4 || r.swd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_bus: addr=%h wd=%h want 4/deadbeef", r.saddr, r.swd); end
    checks++; if (r.er !== 1'b0 || r.nother !== 0) begin errors++; $display("FAIL wr_err_other: err=%b other=%0d want 0/0", r.er, r.nother); end
    checks++; if (gen_dut[0].mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_memory: got %h want deadbeef", gen_dut[0].mem[4]); end
    xact(0, 0, 1'b0, 32'h10, 32'h0, r);
    checks++; if (r.lat !== 2 || r.nrd !== 1 || r.nwr !== 0) begin errors++; $display("FAIL rd_timing: lat=%0d rd=%0d wr=%0d want 2/1/0", r.lat, r.nrd, r.nwr); end
    checks++; if (r.rd !== 32'hDEADBEEF || r.er !== 1'b0) begin errors++; $display("FAIL rd_data: rdata=%h err=%b want deadbeef/0", r.rd, r.er); end
  endtask

  task automatic test_out_of_range();
    res_t r;
    xact(0, 0, 1'b0, 32'h11, 32'h0, r);
    ref_last[0] = 0;
    checks++; if (r.lat !== 2 || r.er !== 1'b1 || r.rd !== 32'd0) begin errors++; $display("FAIL misalign: lat=%0d err=%b rdata=%h want 2/1/0", r.lat, r.er, r.rd); end
    checks++; if (r.nrd !== 0 || r.nwr !== 0) begin errors++; $display("FAIL misalign_strobes: rd=%0d wr=%0d want 0/0", r.nrd, r.nwr); end
    xact(2, 1, 1'b0, 32'h400, 32'h0, r);
    ref_last[2] = 1;
    checks++; if (r.lat !== 5) begin errors++; $display("FAIL oor_latency: got %0d want 5", r.lat); end
    checks++; if (r.er !== 1'b1 || r.rd !== 32'd0) begin errors++; $display("FAIL oor_resp: err=%b rdata=%h want 1/0", r.er, r.rd); end
    checks++; if (r.nrd !== 0 || r.nwr !== 0 || r.nother !== 0) begin errors++; $display("FAIL oor_strobes: rd=%0d wr=%0d other=%0d want 0/0/0", r.nrd, r.nwr, r.nother); end
  endtask

  task automatic test_round_robin();
    int seen, exp_p, prev, d0;
    seen = 0; prev = 0; d0 = dual_cnt[0];
    exp_p = 1 - ref_last[0];
    we_v[0] = '0; addr_v[0][0] = 32'h10; addr_v[0][1] = 32'h14;
    req_v[0] = 2'b11;
    for (int t = 0; t < 40 && seen < 4; t++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (ack_v[0][p]) begin
          checks++; if (p !== exp_p) begin errors++; $display("FAIL rr_order #%0d: got m%0d want m%0d", seen, p, exp_p); end
          if (seen > 0) begin
            checks++; if (cyc - prev !== 3) begin errors++; $display("FAIL rr_spacing #%0d: got %0d want 3", seen, cyc - prev); end
          end
          checks++; if (rdata_v[0][p] !== ref_mem[0][4 + p]) begin errors++; $display("FAIL rr_rdata #%0d: got %h want %h", seen, rdata_v[0][p], ref_mem[0][4 + p]); end
          ref_last[0] = p; exp_p = 1 - p; prev = cyc; seen++;
          if (seen == 4) req_v[0] = '0;
        end
      end
    end
    req_v[0] = '0;
    tick();
    checks++; if (seen !== 4) begin errors++; $display("FAIL rr_count: got %0d acks want 4", seen); end
    checks++; if (dual_cnt[0] - d0 !== 0) begin errors++; $display("FAIL rr_dual_ack: got %0d want 0", dual_cnt[0] - d0); end
  endtask

  task automatic test_fixed_prio();
    int seen, prev;
    bit done;
    seen = 0; prev = 0; done = 1'b0;
    we_v[1] = '0; addr_v[1][0] = 32'h20; addr_v[1][1] = 32'h24;
    req_v[1] = 2'b11;
    for (int t = 0; t < 40 && !done; t++) begin
      tick();
      if (ack_v[1][0]) begin
        if (seen > 0) begin
          checks++; if (cyc - prev !== 3) begin errors++; $display("FAIL fp_spacing #%0d: got %0d want 3", seen, cyc - prev); end
        end
        prev = cyc; seen++;
        if (seen == 4) req_v[1][0] = 1'b0;
      end
      if (ack_v[1][1]) begin
        checks++; if (seen !== 4) begin errors++; $display("FAIL fp_m1_early: m1 acked after %0d m0 acks want 4", seen); end
        checks++; if (cyc - prev !== 3) begin errors++; $display("FAIL fp_m1_spacing: got %0d want 3", cyc - prev); end
        req_v[1][1] = 1'b0; done = 1'b1;
      end
    end
    req_v[1] = '0;
    tick();
    ref_last[1] = 1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL fp_m1_never: m1 ack missing, got %b want 1", done); end
  endtask

  task automatic test_random(input int g);
    res_t r;
    for (int n = 0; n < 40; n++) begin
      int          p, mode;
      bit          we, oor;
      logic [31:0] word, addr, wd, exp_rd;
      p    = $urandom_range(0, 1);
      we   = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 9);
      word = (mode == 0) ? 32'(256 + $urandom_range(0, 4000)) : 32'($urandom_range(0, 31));
      addr = (word << 2) | ((mode == 1) ? 32'($urandom_range(1, 3)) : 32'd0);
      wd   = $urandom;
      oor  = ((addr / 4) >= 256) || ((addr % 4) != 0);
      exp_rd = oor ? 32'd0 : ref_mem[g][addr / 4];
      xact(g, p, we, addr, wd, r);
      checks++; if (r.lat !== lat_of(g) + 1) begin errors++; $display("FAIL rnd_latency g%0d #%0d: got %0d want %0d", g, n, r.lat, lat_of(g) + 1); end
      checks++; if (r.er !== oor) begin errors++; $display("FAIL rnd_err g%0d #%0d addr=%h: got %b want %b", g, n, addr, r.er, oor); end
      checks++; if (r.nwr !== ((we && !oor) ? 1 : 0) || r.nrd !== ((!we && !oor) ? lat_of(g) : 0)) begin
        errors++; $display("FAIL rnd_strobes g%0d #%0d: wr=%0d rd=%0d we=%b oor=%b", g, n, r.nwr, r.nrd, we, oor);
      end
      checks++; if (r.nboth !== 0 || r.nother !== 0) begin errors++; $display("FAIL rnd_excl g%0d #%0d: both=%0d other=%0d want 0/0", g, n, r.nboth, r.nother); end
      if (!we) begin
        checks++; if (r.rd !== exp_rd) begin errors++; $display("FAIL rnd_rdata g%0d #%0d addr=%h: got %h want %h", g, n, addr, r.rd, exp_rd); end
      end
      if (!oor) begin
        checks++; if (r.saddr !== addr / 4) begin errors++; $display("FAIL rnd_addr g%0d #%0d: got %h want %h", g, n, r.saddr, addr / 4); end
      end
      if (we && !oor) ref_mem[g][addr / 4] = wd;
      ref_last[g] = p;
    end
  endtask

  task automatic test_reset_abort();
    int a0, a2;
    a0 = ack_cnt[0][0]; a2 = ack_cnt[2][0];
    req_v[0][0] = 1'b1; we_v[0][0] = 1'b1; addr_v[0][0] = 32'h80; wdata_v[0][0] = 32'hA5A50001;
    req_v[2][0] = 1'b1; we_v[2][0] = 1'b1; addr_v[2][0] = 32'h84; wdata_v[2][0] = 32'hA5A50002;
    tick();
    checks++; if ({mwr_v[0], busy_v[2], mwr_v[2]} !== 3'b110) begin errors++; $display("FAIL abort_setup: wr0/busy2/wr2=%b want 110", {mwr_v[0], busy_v[2], mwr_v[2]}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({mwr_v, mrd_v, busy_v, ack_v} !== '0) begin errors++; $display("FAIL abort_immediate: wr=%b rd=%b busy=%b ack=%b want 0", mwr_v, mrd_v, busy_v, ack_v); end
    req_v = '0;
    tick(); tick();
    rst = 1'b0;
    for (int g = 0; g < 3; g++) ref_last[g] = 1;
    repeat (6) tick();
    checks++; if (ack_cnt[0][0] - a0 !== 0 || ack_cnt[2][0] - a2 !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d/%0d want 0/0", ack_cnt[0][0] - a0, ack_cnt[2][0] - a2); end
    checks++; if (gen_dut[0].mem[32] !== ref_mem[0][32] || gen_dut[2].mem[33] !== ref_mem[2][33]) begin
      errors++; $display("FAIL abort_memory: got %h/%h want %h/%h", gen_dut[0].mem[32], gen_dut[2].mem[33], ref_mem[0][32], ref_mem[2][33]);
    end
    test_reset();
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      ref_last[g] = 1;
      for (int i = 0; i < 256; i++) ref_mem[g][i] = 32'd0;
    end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_write_read();
    test_out_of_range();
    test_round_robin();
    test_fixed_prio();
    test_random(0);
    test_random(2);
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
